// File: rtl/shift_reg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_sched_pkg
// Description : Op, state and register-mode encodings for shift_reg_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_sched_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4
    } mode_t;

    function automatic mode_t op_to_mode(input logic [1:0] op);
        case (op)
            OP_LOAD: return MODE_LOAD;
            OP_SHL:  return MODE_SHL;
            OP_SHR:  return MODE_SHR;
            default: return MODE_ROL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_sched_usr_reg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_sched_usr_reg
// Description : WIDTH-bit universal register (hold/load/shl/shr/rol).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_sched_usr_reg
    import shift_reg_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            case (mode)
                MODE_LOAD: r_q <= d;
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sin};
                MODE_SHR:  r_q <= {sin, r_q[WIDTH-1:1]};
                MODE_ROL:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/shift_reg_sched.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_sched
// Description : Round-robin sequencer for two requesters sharing one shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_sched
    import shift_reg_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_count,
    input  logic             req0_sin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_count,
    input  logic             req1_sin,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    state_t           r_state, w_state_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_sin, r_id, r_nop, r_prio, r_done, r_done_id;
    logic [CNT_W-1:0] r_rem;
    mode_t            w_mode;
    logic             w_last, w_acc, w_shift;
    logic [1:0]       w_op;
    logic [CNT_W-1:0] w_cnt;

    assign w_last  = (r_rem == CNT_W'(1));
    assign w_acc   = req0_ready | req1_ready;
    assign w_op    = req1_ready ? req1_op    : req0_op;
    assign w_cnt   = req1_ready ? req1_count : req0_count;
    assign w_shift = (w_op != OP_LOAD);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // r_prio names the requester that wins a tie; it flips away from each grant.
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_mode       = MODE_HOLD;
        case (r_state)
            ST_IDLE: begin
                req0_ready = req0_valid & (~req1_valid | ~r_prio);
                req1_ready = req1_valid & (~req0_valid |  r_prio);
                if (req0_valid | req1_valid) w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_mode = r_nop ? MODE_HOLD : op_to_mode(r_op);
                if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_LOAD;
            r_data    <= '0;
            r_sin     <= 1'b0;
            r_id      <= 1'b0;
            r_nop     <= 1'b0;
            r_rem     <= '0;
            r_prio    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_done <= (r_state == ST_EXEC) && w_last;
            if ((r_state == ST_EXEC) && w_last) r_done_id <= r_id;
            if (r_state == ST_EXEC) begin
                r_rem <= r_rem - CNT_W'(1);
            end else if (w_acc) begin
                r_id   <= req1_ready;
                r_op   <= w_op;
                r_data <= req1_ready ? req1_data : req0_data;
                r_sin  <= req1_ready ? req1_sin  : req0_sin;
                // A zero-count shift still takes one (idle) step so done fires.
                r_rem  <= (!w_shift || w_cnt == '0) ? CNT_W'(1) : w_cnt;
                r_nop  <= w_shift && (w_cnt == '0);
                r_prio <= ~req1_ready;
            end
        end
    end

    shift_reg_sched_usr_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk  (clk),
        .rst  (rst),
        .mode (w_mode),
        .d    (r_data),
        .sin  (r_sin),
        .q    (q)
    );

    assign busy    = (r_state == ST_EXEC);
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_sched
// Description : Scoreboard bench for shift_reg_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_sched;
    import shift_reg_sched_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid, req0_ready, req0_sin;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_data;
    logic [CNT_W-1:0] req0_count;
    logic             req1_valid, req1_ready, req1_sin;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_data;
    logic [CNT_W-1:0] req1_count;
    logic [WIDTH-1:0] q;
    logic             busy, done, done_id;

    shift_reg_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_count(req0_count), .req0_sin(req0_sin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_count(req1_count), .req1_sin(req1_sin),
        .q(q), .busy(busy), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] q;
        int               cyc;
    } exp_t;

    int               cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    exp_t             sb[$];
    int               gq[$];
    logic [WIDTH-1:0] m_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] qi, input logic [1:0] op,
                                               input logic [WIDTH-1:0] d, input int n, input logic s);
        logic [WIDTH-1:0] r;
        r = qi;
        if (op == OP_LOAD) return d;
        for (int i = 0; i < n; i++) begin
            case (op)
                OP_SHL:  r = {r[WIDTH-2:0], s};
                OP_SHR:  r = {s, r[WIDTH-1:1]};
                default: r = {r[WIDTH-2:0], r[WIDTH-1]};
            endcase
        end
        return r;
    endfunction

    task automatic accept(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d,
                          input logic [CNT_W-1:0] c, input logic s);
        int   n;
        exp_t e;
        n = (op == OP_LOAD || c == '0) ? 1 : int'(c);
        if (op == OP_LOAD || c != '0) m_q = model(m_q, op, d, n, s);
        e.id  = id;
        e.q   = m_q;
        e.cyc = cyc + n + 1;
        sb.push_back(e);
        gq.push_back(id);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("excl_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (busy) chk("ready_in_exec", 32'(req0_ready | req1_ready), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("done_q", 32'(q), 32'(e.q));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (req0_valid && req0_ready) accept(0, req0_op, req0_data, req0_count, req0_sin);
            if (req1_valid && req1_ready) accept(1, req1_op, req1_data, req1_count, req1_sin);
        end
    end

    task automatic send(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d,
                        input logic [CNT_W-1:0] c, input logic s, output int t);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_data = d; req0_count = c; req0_sin = s;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = d; req1_count = c; req1_sin = s;
        end
        t = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (id == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int t, ts;
        req0_valid = 0; req0_op = '0; req0_data = '0; req0_count = '0; req0_sin = 0;
        req1_valid = 0; req1_op = '0; req1_data = '0; req1_count = '0; req1_sin = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);

        // LOAD: busy at T+1, result and done at T+2
        send(0, OP_LOAD, 4'b1010, 3'd0, 1'b0, t);
        chk("load_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("load_q", 32'(q), 32'b1010);
        chk("load_done", 32'(done), 32'd1);
        chk("load_done_id", 32'(done_id), 32'd0);
        drain();

        // SHL x2 with sin=1
        send(1, OP_SHL, 4'b0000, 3'd2, 1'b1, t);
        chk("shl_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("shl_step1", 32'(q), 32'b0101);
        drain();
        chk("shl_final", 32'(q), 32'b1011);

        // SHR x3 then ROL accepted in the done cycle
        send(0, OP_SHR, 4'b0000, 3'd3, 1'b0, t);
        ts = t;
        send(0, OP_ROL, 4'b0000, 3'd1, 1'b0, t);
        chk("b2b_accept_cycle", 32'(t), 32'(ts + 4));
        chk("shr_final", 32'(q), 32'b0001);
        drain();
        chk("rol_final", 32'(q), 32'b0010);

        // zero-count shift is a one-step no-op
        send(1, OP_SHL, 4'b0000, 3'd0, 1'b1, t);
        drain();
        chk("nop_q", 32'(q), 32'b0010);

        // reset in the middle of ROL x5
        send(0, OP_ROL, 4'b0000, 3'd5, 1'b0, t);
        @(posedge clk); #1;
        chk("rol5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        m_q = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // both valid: grants alternate starting with req0
        gq.delete();
        req0_valid = 1'b1; req0_op = OP_LOAD; req0_data = 4'h3; req0_count = '0;
        req1_valid = 1'b1; req1_op = OP_LOAD; req1_data = 4'hC; req1_count = '0;
        for (int k = 0; k < 40 && gq.size() < 4; k++) begin
            @(posedge clk);
            #2;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        if (gq.size() < 4) chk("tie_grant_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk($sformatf("tie_grant%0d", i), 32'(gq[i]), 32'(i % 2));

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
